ysyx_24100006_lsu_axim: RTL
===========================

YSYX_24100006_LSU_AXIM -- requirements
Module: ysyx_24100006_lsu_axim

Interface
REQ-001 SHALL: clk  in  1  clock, all logic on rising edge.
REQ-002 SHALL: reset  in  1  reset, synchronous, active-high.
REQ-003 SHALL: req_valid  in  1  LSU request valid.
REQ-004 SHALL: req_ready  out  1  request accepted when high with req_valid.
REQ-005 SHALL: req_wen  in  1  1=store, 0=load.
REQ-006 SHALL: req_op  in  3  funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu.
REQ-007 SHALL: req_addr  in  32  byte address.
REQ-008 SHALL: req_wdata  in  32  store data, right-aligned.
REQ-009 SHALL: resp_valid  out  1  one-cycle completion pulse.
REQ-010 SHALL: resp_rdata  out  32  aligned, extended load data; 0 for stores.
REQ-011 SHALL: resp_err  out  1  error flag, valid with resp_valid.
REQ-012 SHALL: axi_araddr/axi_arvalid  out  32/1  read-address channel; axi_arready  in  1.
REQ-013 SHALL: axi_rdata/axi_rresp/axi_rvalid  in  32/2/1  read-data channel; axi_rready  out  1.
REQ-014 SHALL: axi_awaddr/axi_awvalid  out  32/1  write-address channel; axi_awready  in  1.
REQ-015 SHALL: axi_wdata/axi_wstrb/axi_wvalid  out  32/8/1  write-data channel; axi_wready  in  1.
REQ-016 SHALL: axi_bresp/axi_bvalid  in  2/1  write response; axi_bready  out  1.

Function
REQ-017 SHALL: FSM states IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP; req_ready=1 only in IDLE, registered.
REQ-018 SHALL: IDLE + req_valid: latch req_*; load -> RD_ADDR with axi_arvalid=1 next cycle; store -> WR_REQ with axi_awvalid=axi_wvalid=1 next cycle.
REQ-019 SHALL: axi_araddr/axi_awaddr = latched addr with [1:0] cleared; held stable while the corresponding valid is high.
REQ-020 SHALL: RD_ADDR: on arvalid&arready, drop arvalid, raise rready, go RD_DATA; on rvalid&rready, drop rready, pulse resp_valid, return IDLE.
REQ-021 SHALL: WR_REQ: awvalid and wvalid each drop independently on own handshake, both in the same cycle if both handshake; once both done, raise bready, go WR_RESP; on bvalid&bready, drop bready, pulse resp_valid, return IDLE.
REQ-022 SHALL: axi_wdata = req_wdata shifted left by 8*addr[1:0]; axi_wstrb[3:0] = 0001/0011/1111 (b/h/w) shifted left by addr[1:0], wstrb[7:4]=0.
REQ-023 SHALL: load data = axi_rdata shifted right by 8*addr[1:0], then sign-extended (b,h) or zero-extended (bu,hu) from bit 7/15; w unchanged.
REQ-024 SHALL: resp_err = (rresp or bresp != 2'b00); resp_rdata still driven from rdata.
REQ-025 SHALL: at most one transaction outstanding; req_valid ignored outside IDLE; response cannot be back-pressured.
REQ-026 SHALL: minimum latency, zero-wait slave: load 3 cycles, store 3 cycles from acceptance to resp_valid.

Reset
REQ-027 SHALL: reset (any state, incl. mid-transaction) -> IDLE; req_ready=0 in the reset cycle, then 1; all valids/readies, resp_valid, resp_err=0; resp_rdata, axi addr/data/wstrb=0; the in-flight transaction is abandoned with no response.

Configuration
REQ-028 SHALL: with LSU_AXIM_ALIGN_CHECK_EN defined, a misaligned h/hu (addr[0]=1) or w (addr[1:0]!=0) request issues no AXI transaction and gives resp_valid=1, resp_err=1, resp_rdata=0 one cycle after acceptance.
REQ-029 SHALL: without LSU_AXIM_ALIGN_CHECK_EN, misaligned requests proceed per REQ-022/023 with no error flagged.

Verification
REQ-030 SHALL: load lb addr 0x80000003, slave rdata 0x80FF1234, rresp 0 -> resp_rdata 0xFFFFFF80, resp_err 0.
REQ-031 SHALL: store sh addr 0x80000002, wdata 0x0000ABCD -> awaddr 0x80000000, wdata 0xABCD0000, wstrb 0x0C.
REQ-032 SHALL: store with awready a cycle before wready -> awvalid drops first, wvalid held, single bready handshake, one resp_valid.
REQ-033 SHALL: load with rresp=2'b10 -> resp_valid with resp_err=1; reset asserted during RD_DATA -> IDLE, no resp_valid.
REQ-034 SHALL: lw addr 0x80000001 -> with ALIGN_CHECK_EN: no arvalid, resp_err=1 next cycle; without: arvalid, araddr 0x80000000.

Source files
------------

// File: rtl/ysyx_24100006_lsu_axim_if.sv
// ysyx_24100006_lsu_axim_if: AXI4-lite style bus between the LSU master and a memory slave
//   read address : araddr, arvalid (master) / arready (slave)
//   read data    : rdata, rresp, rvalid (slave) / rready (master)
//   write address: awaddr, awvalid (master) / awready (slave)
//   write data   : wdata, wstrb, wvalid (master) / wready (slave)
//   write resp   : bresp, bvalid (slave) / bready (master)
interface ysyx_24100006_lsu_axim_if;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [7:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  modport master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
  modport slave (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/ysyx_24100006_lsu_axim.sv
// ysyx_24100006_lsu_axim: LSU-to-AXI master, one outstanding load/store at a time
//   clk, reset (sync, active-high)
//   req_valid/req_ready, req_wen, req_op (funct3), req_addr, req_wdata : LSU request
//   resp_valid (1-cycle pulse), resp_rdata (extended load data, 0 for stores), resp_err
//   axi (master modport) : AR/R/AW/W/B channels, word-aligned addresses, byte strobes
//   Optional: define LSU_AXIM_ALIGN_CHECK_EN to reject misaligned h/hu/w requests
//   with an immediate error response and no bus traffic.
module ysyx_24100006_lsu_axim (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic                            req_wen,
  input  logic [2:0]                      req_op,
  input  logic [31:0]                     req_addr,
  input  logic [31:0]                     req_wdata,
  output logic                            resp_valid,
  output logic [31:0]                     resp_rdata,
  output logic                            resp_err,
  ysyx_24100006_lsu_axim_if.master        axi
);
  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP} state_t;
  state_t      state_q, state_d;
  logic        req_ready_q, req_ready_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] wdata_q, wdata_d;
  logic [7:0]  wstrb_q, wstrb_d;
  logic        arvalid_q, arvalid_d;
  logic        rready_q, rready_d;
  logic        awvalid_q, awvalid_d;
  logic        wvalid_q, wvalid_d;
  logic        bready_q, bready_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_err_q, resp_err_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        misal, aw_done, w_done;
  logic [3:0]  strb_m, strb_s;
  logic [31:0] rshift, load_data;
`ifdef LSU_AXIM_ALIGN_CHECK_EN
  assign misal = (req_op[1:0] == 2'b01 && req_addr[0]) || (req_op[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
`else
  assign misal = 1'b0;
`endif
  // strobe mask truncates at the word boundary for misaligned stores
  assign strb_m    = req_op[1:0] == 2'b00 ? 4'b0001 : req_op[1:0] == 2'b01 ? 4'b0011 : 4'b1111;
  assign strb_s    = strb_m << req_addr[1:0];
  assign rshift    = axi.rdata >> {addr_q[1:0], 3'b000};
  // op_q[2] marks the unsigned variants (bu/hu)
  assign load_data = op_q[1:0] == 2'b00 ? {{24{~op_q[2] & rshift[7]}}, rshift[7:0]} :
                     op_q[1:0] == 2'b01 ? {{16{~op_q[2] & rshift[15]}}, rshift[15:0]} : rshift;
  // a channel is done once its valid has already dropped or handshakes now
  assign aw_done   = !awvalid_q || axi.awready;
  assign w_done    = !wvalid_q || axi.wready;
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    op_d         = op_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    arvalid_d    = arvalid_q;
    rready_d     = rready_q;
    awvalid_d    = awvalid_q;
    wvalid_d     = wvalid_q;
    bready_d     = bready_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = resp_rdata_q;
    case (state_q)
      IDLE: if (req_valid && req_ready_q) begin
        addr_d = req_addr;
        op_d   = req_op;
        if (misal) begin
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
          resp_rdata_d = 32'h0;
        end else if (req_wen) begin
          state_d   = WR_REQ;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          wdata_d   = req_wdata << {req_addr[1:0], 3'b000};
          wstrb_d   = {4'b0000, strb_s};
        end else begin
          state_d   = RD_ADDR;
          arvalid_d = 1'b1;
        end
      end
      RD_ADDR: if (arvalid_q && axi.arready) begin
        arvalid_d = 1'b0;
        rready_d  = 1'b1;
        state_d   = RD_DATA;
      end
      RD_DATA: if (rready_q && axi.rvalid) begin
        rready_d     = 1'b0;
        resp_valid_d = 1'b1;
        resp_err_d   = |axi.rresp;
        resp_rdata_d = load_data;
        state_d      = IDLE;
      end
      WR_REQ: begin
        awvalid_d = awvalid_q && !axi.awready;
        wvalid_d  = wvalid_q && !axi.wready;
        if (aw_done && w_done) begin
          bready_d = 1'b1;
          state_d  = WR_RESP;
        end
      end
      WR_RESP: if (bready_q && axi.bvalid) begin
        bready_d     = 1'b0;
        resp_valid_d = 1'b1;
        resp_err_d   = |axi.bresp;
        resp_rdata_d = 32'h0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
    req_ready_d = state_d == IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b0;
      addr_q       <= 32'h0;
      op_q         <= 3'h0;
      wdata_q      <= 32'h0;
      wstrb_q      <= 8'h0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      addr_q       <= addr_d;
      op_q         <= op_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      bready_q     <= bready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end
  assign req_ready   = req_ready_q;
  assign resp_valid  = resp_valid_q;
  assign resp_err    = resp_err_q;
  assign resp_rdata  = resp_rdata_q;
  assign axi.araddr  = {addr_q[31:2], 2'b00};
  assign axi.awaddr  = {addr_q[31:2], 2'b00};
  assign axi.arvalid = arvalid_q;
  assign axi.rready  = rready_q;
  assign axi.awvalid = awvalid_q;
  assign axi.wvalid  = wvalid_q;
  assign axi.wdata   = wdata_q;
  assign axi.wstrb   = wstrb_q;
  assign axi.bready  = bready_q;
endmodule
